// File: rtl/pwm_duty_capture.sv
// PWM duty capture: measures high time and rising-to-rising period of an async
// PWM input and exposes them as Avalon-MM read-only registers with a loss-of-signal timeout.
module pwm_duty_capture #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 2000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        pwm_in,
   output logic        irq
);

   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0]    TERM = IW'(TIMEOUT - 1);
   localparam logic [IW-1:0]    TSAT = IW'(TIMEOUT);
   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

   typedef struct packed {
      logic irq_en;
      logic tout;
      logic valid;
   } status_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CMAX) ? v : v + ONE;
   endfunction

   logic sync1, sync2, lvl, rise, fall;
   logic [IW-1:0] icnt;
   logic tout_hit;
   state_t state, state_nxt;
   logic [CNT_W-1:0] hcnt, pcnt, hcnt_nxt, pcnt_nxt;
   logic [CNT_W-1:0] high, period;
   logic publish;
   status_t status;
   logic wr;
   logic unused_wd;

   assign unused_wd = ^writedata[31:3];
   assign wr = chipselect & ~write_n & (address == 2'd2);

   // rise/fall are registered, so both edges see the same 3-cycle offset
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         lvl   <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= pwm_in;
         sync2 <= sync1;
         lvl   <= sync2;
         rise  <= sync2 & ~lvl;
         fall  <= ~sync2 & lvl;
      end
   end

   // idle counter parks one past terminal so the timeout fires once per loss
   assign tout_hit = (icnt == TERM) && !rise && !fall;

   always_ff @(posedge clk) begin
      if (reset)             icnt <= '0;
      else if (rise || fall) icnt <= '0;
      else if (icnt != TSAT) icnt <= icnt + 1'b1;
   end

   always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      pcnt_nxt  = pcnt;
      publish   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (rise) begin
               state_nxt = S_HI;
               hcnt_nxt  = ONE;
               pcnt_nxt  = ONE;
            end
         end
         S_HI: begin
            pcnt_nxt = sat_inc(pcnt);
            if (fall) state_nxt = S_LO;
            else      hcnt_nxt  = sat_inc(hcnt);
         end
         S_LO: begin
            if (rise) begin
               publish   = 1'b1;
               state_nxt = S_HI;
               hcnt_nxt  = ONE;
               pcnt_nxt  = ONE;
            end else begin
               pcnt_nxt = sat_inc(pcnt);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (tout_hit) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         hcnt  <= '0;
         pcnt  <= '0;
      end else begin
         state <= state_nxt;
         hcnt  <= hcnt_nxt;
         pcnt  <= pcnt_nxt;
      end
   end

   // hardware set beats a same-cycle W1C
   always_ff @(posedge clk) begin
      if (reset) begin
         high   <= '0;
         period <= '0;
         status <= '0;
      end else begin
         if (publish) begin
            high   <= hcnt;
            period <= pcnt;
         end else if (tout_hit) begin
            high   <= '0;
            period <= '0;
         end
         status.valid <= publish  | (status.valid & ~(wr & writedata[0]));
         status.tout  <= tout_hit | (status.tout  & ~(wr & writedata[1]));
         if (wr) status.irq_en <= writedata[2];
      end
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         2'd0:    readdata = 32'(high);
         2'd1:    readdata = 32'(period);
         2'd2:    readdata = {29'd0, status.irq_en, status.tout, status.valid};
         default: readdata = '0;
      endcase
   end

   assign irq = status.irq_en & (status.valid | status.tout);

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture: two instances (32-bit and 8-bit counters) share one
// stimulus; expectations come from absolute edge times of the driven waveform.
module tb_pwm_duty_capture;

   localparam int TO = 5000;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic        pwm_in;
   logic [31:0] rd_a, rd_b;
   logic        irq_a, irq_b;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   int m_high, m_per;
   bit m_valid, m_tout, m_ien, armed;
   int t_rise_prev, t_fall_prev;

   pwm_duty_capture #(.CNT_W(32), .TIMEOUT(TO)) dut_a (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_a),
      .pwm_in(pwm_in), .irq(irq_a)
   );

   pwm_duty_capture #(.CNT_W(8), .TIMEOUT(TO)) dut_b (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_b),
      .pwm_in(pwm_in), .irq(irq_b)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, cyc=%0d required < 100000", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
   endtask

   function automatic int sat8(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   // call just after a negedge; each read settles 1ns
   task automatic check_regs(input string tag);
      logic [31:0] st;
      logic        ei;
      st = {29'd0, m_ien, m_tout, m_valid};
      ei = m_ien & (m_valid | m_tout);
      address = 2'd0; #1;
      chk({tag, ":a_high"}, rd_a, m_high);
      chk({tag, ":b_high"}, rd_b, sat8(m_high));
      address = 2'd1; #1;
      chk({tag, ":a_per"}, rd_a, m_per);
      chk({tag, ":b_per"}, rd_b, sat8(m_per));
      address = 2'd2; #1;
      chk({tag, ":a_stat"}, rd_a, st);
      chk({tag, ":b_stat"}, rd_b, st);
      address = 2'd3; #1;
      chk({tag, ":a_r3"}, rd_a, 32'd0);
      chk({tag, ":a_irq"}, {31'd0, irq_a}, {31'd0, ei});
      chk({tag, ":b_irq"}, {31'd0, irq_b}, {31'd0, ei});
   endtask

   task automatic model_reset();
      m_high = 0; m_per = 0; m_valid = 0; m_tout = 0; m_ien = 0; armed = 0;
   endtask

   // entry/exit: 1ns after a posedge
   task automatic wr_status(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
      if (a == 2'd2) begin
         if (d[0]) m_valid = 0;
         if (d[1]) m_tout = 0;
         m_ien = d[2];
      end
   endtask

   task automatic wr_and_check(input string tag, input logic [1:0] a, input logic [31:0] d);
      wr_status(a, d);
      @(negedge clk);
      check_regs(tag);
      @(posedge clk); #1;
   endtask

   // one PWM period: h cycles high, then l cycles low; w1c writes STATUS=1
   // on the very edge where a published sample would set VALID
   task automatic pulse(input int h, input int l, input bit w1c);
      bit pub;
      int nh, np;
      pwm_in = 1'b1;
      pub = armed;
      nh = t_fall_prev - t_rise_prev;
      np = cyc - t_rise_prev;
      t_rise_prev = cyc;
      armed = 1;
      repeat (4) @(negedge clk);
      check_regs("pre");
      if (w1c) begin
         address = 2'd2; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
      end
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      if (pub) begin
         m_high = nh; m_per = np; m_valid = 1;
      end else if (w1c) begin
         m_valid = 0;
      end
      if (w1c) m_ien = 0;
      check_regs(w1c ? "post_w1c" : "post");
      repeat (h - 4) @(posedge clk); #1;
      pwm_in = 1'b0;
      t_fall_prev = cyc;
      repeat (l) @(posedge clk); #1;
   endtask

   task automatic do_timeout();
      int target;
      target = t_fall_prev + 3 + TO;
      while (1) begin
         @(negedge clk);
         if (cyc >= target) break;
      end
      check_regs("to_pre");
      @(negedge clk);
      m_high = 0; m_per = 0; m_tout = 1; armed = 0;
      check_regs("to_post");
      @(posedge clk); #1;
   endtask

   task automatic reset_mid_hi();
      pwm_in = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1; pwm_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check_regs("rst_hi");
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; pwm_in = 1'b0;
      t_rise_prev = 0; t_fall_prev = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_regs("reset");
      @(posedge clk); #1;

      wr_and_check("ien", 2'd2, 32'h4);
      for (int i = 0; i < 4; i++) pulse(100, 900, 1'b0);

      pulse(40, 60, 1'b1);
      wr_and_check("w1c_idle", 2'd2, 32'h5);
      wr_and_check("addr3", 2'd3, 32'h7);

      for (int i = 0; i < 15; i++)
         pulse($urandom_range(5, 300), $urandom_range(1, 300), ($urandom_range(0, 3) == 0));

      pulse(300, 50, 1'b0);
      pulse(300, 50, 1'b0);
      pulse(20, 20, 1'b0);

      wr_and_check("ien2", 2'd2, 32'h4);
      pulse(50, 100, 1'b0);
      pulse(50, 100, 1'b0);
      do_timeout();
      wr_and_check("clr_to", 2'd2, 32'h6);
      wr_and_check("clr_v", 2'd2, 32'h1);

      reset_mid_hi();
      pulse(30, 40, 1'b0);
      pulse(30, 40, 1'b0);
      pulse(30, 40, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
